ula_chain_ctrl: RTL and testbench

Multi-byte sequencer placed directly upstream of the 8-bit ALU (`ula_8_bits`). It accepts an NBYTES-wide command over a valid/ready handshake and feeds the ALU one byte per cycle, least-significant byte first. Between bytes it forwards the true carry, correcting the ALU's carry polarity for each operation. It then assembles the wide result and flags and returns them over a second valid/ready handshake.

---
 rtl/ula_chain_pkg.sv | 23 ++
 rtl/ula_chain_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ula_chain_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_chain_pkg.sv
// Shared types and helpers for the ula_chain_ctrl multi-byte ALU sequencer.
// Holds the FSM encoding, the NBYTES limits and the carry-polarity table of ula_8_bits.
package ula_chain_pkg;

  localparam int NBYTES_MIN = 1;
  localparam int NBYTES_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // ula_8_bits reports an inverted carry-out for these function codes.
  function automatic logic inv_carry(input logic [3:0] s);
    case (s)
      4'b0000, 4'b0010, 4'b0011,
      4'b0110, 4'b0111, 4'b1011: inv_carry = 1'b1;
      default:                   inv_carry = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ula_chain_ctrl.sv
// Feeds an NBYTES-wide command through the 8-bit ALU one byte per step, LSB first.
// Build option ULA_CHAIN_PIPE_IN_EN registers the ALU outputs (2 cycles per byte).
module ula_chain_ctrl
  import ula_chain_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_s,
  input  logic                cmd_m,
  input  logic                cmd_cin,
  input  logic [8*NBYTES-1:0] cmd_a,
  input  logic [8*NBYTES-1:0] cmd_b,
  output logic [7:0]          ula_a,
  output logic [7:0]          ula_b,
  output logic [3:0]          ula_s,
  output logic                ula_m,
  output logic                ula_cin,
  input  logic [7:0]          ula_f,
  input  logic                ula_cout,
  input  logic                ula_ovf,
  input  logic                ula_aeqb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_f,
  output logic                rsp_cout,
  output logic                rsp_ovf,
  output logic                rsp_zero,
  output logic                rsp_aeqb
);

  localparam int W = 8 * NBYTES;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_EXEC  = EXEC;
  localparam logic [1:0] ST_RESP  = RESP;
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  logic [1:0]   state_q, state_d;
  logic         alive_q;
  logic [3:0]   s_q;
  logic         m_q;
  logic         cin_q;
  logic [W-1:0] a_q, b_q, res_q;
  logic [1:0]   idx_q;
  logic         carry_q;
  logic         aeqb_q;
  logic         cout_q;
  logic         ovf_q;

  logic         accept;
  logic         cap_en;
  logic [7:0]   f_use;
  logic         cout_use, ovf_use, aeqb_use;

  // alive_q keeps cmd_ready low until the first clock edge after reset is released.
  assign cmd_ready = alive_q && (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef ULA_CHAIN_PIPE_IN_EN
  logic       phase_q;
  logic [7:0] f_r;
  logic       cout_r, ovf_r, aeqb_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      f_r     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      aeqb_r  <= 1'b0;
    end else begin
      phase_q <= (state_q == ST_EXEC) ? ~phase_q : 1'b0;
      f_r     <= ula_f;
      cout_r  <= ula_cout;
      ovf_r   <= ula_ovf;
      aeqb_r  <= ula_aeqb;
    end
  end

  // Phase 0 drives the byte, phase 1 consumes the registered ALU result.
  assign cap_en   = (state_q == ST_EXEC) && phase_q;
  assign f_use    = f_r;
  assign cout_use = cout_r;
  assign ovf_use  = ovf_r;
  assign aeqb_use = aeqb_r;
`else
  assign cap_en   = (state_q == ST_EXEC);
  assign f_use    = ula_f;
  assign cout_use = ula_cout;
  assign ovf_use  = ula_ovf;
  assign aeqb_use = ula_aeqb;
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: if (cap_en && (idx_q == LAST_IDX)) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ula_a   = '0;
    ula_b   = '0;
    ula_s   = '0;
    ula_m   = 1'b0;
    ula_cin = 1'b0;
    if (state_q == ST_EXEC) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (int'(idx_q) == i) begin
          ula_a = a_q[8*i +: 8];
          ula_b = b_q[8*i +: 8];
        end
      end
      ula_s   = s_q;
      ula_m   = m_q;
      ula_cin = (idx_q == 2'd0) ? cin_q : (carry_q & ~m_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      alive_q <= 1'b0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      aeqb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (accept) begin
        s_q     <= cmd_s;
        m_q     <= cmd_m;
        cin_q   <= cmd_cin;
        a_q     <= cmd_a;
        b_q     <= cmd_b;
        res_q   <= '0;
        idx_q   <= '0;
        carry_q <= 1'b0;
        aeqb_q  <= 1'b1;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (cap_en) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (int'(idx_q) == i) res_q[8*i +: 8] <= f_use;
        end
        aeqb_q  <= aeqb_q & aeqb_use;
        // Normalise to a true carry so the next byte always sees "1 = add one".
        carry_q <= cout_use ^ inv_carry(s_q);
        if (idx_q == LAST_IDX) begin
          cout_q <= m_q ? 1'b0 : cout_use;
          ovf_q  <= m_q ? 1'b0 : ovf_use;
        end else begin
          idx_q <= idx_q + 2'd1;
        end
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_f     = res_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_zero  = rsp_valid && (res_q == '0);
  assign rsp_aeqb  = aeqb_q;

endmodule

// File: tb/tb_ula_chain_ctrl.sv
// Self-checking bench for ula_chain_ctrl (NBYTES=2) with a behavioural ula_8_bits attached.
// Results are compared against a wide-word reference model of the ALU functions.
module tb_ula_chain_ctrl;

  localparam int NB = 2;
  localparam int W  = 8 * NB;
`ifdef ULA_CHAIN_PIPE_IN_EN
  localparam int CPB = 2;
`else
  localparam int CPB = 1;
`endif
  localparam int LAT = CPB * NB;

  typedef struct packed {
    logic [W-1:0] f;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         aeqb;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_s = '0;
  logic         cmd_m = 1'b0;
  logic         cmd_cin = 1'b0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [7:0]   ula_a, ula_b;
  logic [3:0]   ula_s;
  logic         ula_m, ula_cin;
  logic [7:0]   ula_f;
  logic         ula_cout, ula_ovf, ula_aeqb;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_f;
  logic         rsp_cout, rsp_ovf, rsp_zero, rsp_aeqb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ula_chain_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_s(cmd_s), .cmd_m(cmd_m), .cmd_cin(cmd_cin), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ula_a(ula_a), .ula_b(ula_b), .ula_s(ula_s), .ula_m(ula_m), .ula_cin(ula_cin),
    .ula_f(ula_f), .ula_cout(ula_cout), .ula_ovf(ula_ovf), .ula_aeqb(ula_aeqb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_aeqb(rsp_aeqb)
  );

  // Arithmetic functions as two addends {x, y}; the result is x + y + cin at width w.
  function automatic logic [63:0] arith_terms(input logic [3:0] s, input logic [31:0] a,
                                              input logic [31:0] b, input int w);
    logic [31:0] m, nb, x, y;
    m  = (32'd1 << w) - 32'd1;
    nb = ~b & m;
    case (s)
      4'h0: begin x = a;       y = '0;     end
      4'h1: begin x = a | b;   y = '0;     end
      4'h2: begin x = a | nb;  y = '0;     end
      4'h3: begin x = '0;      y = m;      end
      4'h4: begin x = a;       y = a & nb; end
      4'h5: begin x = a | b;   y = a & nb; end
      4'h6: begin x = a;       y = nb;     end
      4'h7: begin x = a & nb;  y = m;      end
      4'h8: begin x = a;       y = a & b;  end
      4'h9: begin x = a;       y = b;      end
      4'hA: begin x = a | nb;  y = a & b;  end
      4'hB: begin x = a & b;   y = m;      end
      4'hC: begin x = a;       y = a;      end
      4'hD: begin x = a | b;   y = a;      end
      4'hE: begin x = a | nb;  y = a;      end
      default: begin x = a;    y = m;      end
    endcase
    return {x & m, y & m};
  endfunction

  function automatic logic [31:0] logic_fn(input logic [3:0] s, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
    logic [31:0] m, r;
    m = (32'd1 << w) - 32'd1;
    case (s)
      4'h0: r = ~a;        4'h1: r = ~(a | b);  4'h2: r = ~a & b;   4'h3: r = '0;
      4'h4: r = ~(a & b);  4'h5: r = ~b;        4'h6: r = a ^ b;    4'h7: r = a & ~b;
      4'h8: r = ~a | b;    4'h9: r = ~(a ^ b);  4'hA: r = b;        4'hB: r = a & b;
      4'hC: r = m;         4'hD: r = a | ~b;    4'hE: r = a | b;    default: r = a;
    endcase
    return r & m;
  endfunction

  function automatic logic spec_inv(input logic [3:0] s);
    return (s == 4'h0) || (s == 4'h2) || (s == 4'h3) || (s == 4'h6) || (s == 4'h7) || (s == 4'hB);
  endfunction

  // Behavioural ula_8_bits; logic mode deliberately reports cout/ovf high.
  logic [63:0] alu_t;
  logic [31:0] alu_l;
  logic [32:0] alu_sum;
  always_comb begin
    alu_t    = arith_terms(ula_s, {24'd0, ula_a}, {24'd0, ula_b}, 8);
    alu_l    = logic_fn(ula_s, {24'd0, ula_a}, {24'd0, ula_b}, 8);
    alu_sum  = {1'b0, alu_t[63:32]} + {1'b0, alu_t[31:0]} + {32'd0, ula_cin};
    ula_f    = alu_sum[7:0];
    ula_cout = alu_sum[8] ^ spec_inv(ula_s);
    ula_ovf  = (alu_t[39] == alu_t[7]) && (alu_sum[7] != alu_t[39]);
    if (ula_m) begin
      ula_f    = alu_l[7:0];
      ula_cout = 1'b1;
      ula_ovf  = 1'b1;
    end
    ula_aeqb = (ula_f == 8'hFF);
  end

  // Wide-word reference: the function applied to the full operands in one step.
  function automatic resp_t ref_model(input logic [3:0] s, input logic m, input logic cin,
                                      input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] t;
    logic [31:0] x, y, l;
    logic [32:0] sum;
    resp_t r;
    t = arith_terms(s, 32'(a), 32'(b), W);
    x = t[63:32];
    y = t[31:0];
    l = logic_fn(s, 32'(a), 32'(b), W);
    sum = 33'(x) + 33'(y) + 33'(cin);
    if (m) begin
      r.f = l[W-1:0]; r.cout = 1'b0; r.ovf = 1'b0;
    end else begin
      r.f    = sum[W-1:0];
      r.cout = sum[W] ^ spec_inv(s);
      r.ovf  = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
    end
    r.zero = (r.f == '0);
    r.aeqb = &r.f;
    return r;
  endfunction

  // Carry entering each byte of the wide addition (byte 0 sees cin).
  function automatic logic [NB-1:0] ref_cins(input logic [3:0] s, input logic m, input logic cin,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] t;
    logic [31:0] x, y, c;
    logic [32:0] sum;
    logic [NB-1:0] r;
    t = arith_terms(s, 32'(a), 32'(b), W);
    x = t[63:32];
    y = t[31:0];
    sum = 33'(x) + 33'(y) + 33'(cin);
    c = sum[31:0] ^ x ^ y;
    for (int k = 0; k < NB; k++) r[k] = (k == 0) ? cin : (m ? 1'b0 : c[8*k]);
    return r;
  endfunction

  function automatic logic [43:0] all_outs();
    return {cmd_ready, rsp_valid, rsp_f, rsp_cout, rsp_ovf, rsp_zero, rsp_aeqb,
            ula_a, ula_b, ula_s, ula_m, ula_cin};
  endfunction

  // Issue one command and collect what the DUT did; always left at #1 after an edge.
  task automatic run_cmd(input logic [3:0] s, input logic m, input logic cin,
                         input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                         output resp_t got, output int lat, output logic [NB-1:0] cins,
                         output logic held, output logic ready_after);
    int guard;
    resp_t snap;
    guard = 0; lat = -1; cins = '0; held = 1'b1; got = '0; ready_after = 1'b0;
    while (!cmd_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    cmd_valid = 1'b1; cmd_s = s; cmd_m = m; cmd_cin = cin; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_s = 4'($urandom); cmd_m = 1'($urandom);
    cmd_cin = 1'($urandom); cmd_a = W'($urandom); cmd_b = W'($urandom);
    for (int c = 0; c <= 4 * LAT; c++) begin
      if ((c % CPB == 0) && (c / CPB < NB)) cins[c / CPB] = ula_cin;
      if (rsp_valid) begin lat = c; break; end
      @(posedge clk); #1;
    end
    if (lat < 0) return;
    got = {rsp_f, rsp_cout, rsp_ovf, rsp_zero, rsp_aeqb};
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      snap = {rsp_f, rsp_cout, rsp_ovf, rsp_zero, rsp_aeqb};
      if (snap !== got || !rsp_valid || cmd_ready) held = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    ready_after = cmd_ready && !rsp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_a = 16'hFFFF; cmd_b = 16'hFFFF; cmd_s = 4'h9;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_release_ready: got %b expected 0", cmd_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_after_first_clock: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic directed(input string name, input logic [3:0] s, input logic m, input logic cin,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input resp_t exp, input logic exp_cin1);
    resp_t got; int lat; logic [NB-1:0] cins; logic held, rdy;
    run_cmd(s, m, cin, a, b, 0, got, lat, cins, held, rdy);
    vectors++;
    if (lat != LAT) begin
      miscompares++; $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
    end
    vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL %s response: got %h expected %h", name, got, exp);
    end
    vectors++;
    if (cins[1] !== exp_cin1) begin
      miscompares++; $display("FAIL %s byte1_cin: got %b expected %b", name, cins[1], exp_cin1);
    end
  endtask

  task automatic test_add_ripple();
    directed("add_ripple", 4'b1001, 1'b0, 1'b0, 16'h00FF, 16'h0001, {16'h0100, 4'b0000}, 1'b1);
  endtask

  task automatic test_subtract();
    directed("subtract", 4'b0110, 1'b0, 1'b1, 16'h1234, 16'h0235, {16'h0FFF, 4'b0000}, 1'b0);
  endtask

  task automatic test_overflow_zero();
    directed("overflow", 4'b1001, 1'b0, 1'b0, 16'h7FFF, 16'h0001, {16'h8000, 4'b0100}, 1'b1);
    directed("wrap_zero", 4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, {16'h0000, 4'b1010}, 1'b1);
  endtask

  task automatic test_logic_xor();
    directed("logic_xor", 4'b0110, 1'b1, 1'b1, 16'hAA55, 16'hFFFF, {16'h55AA, 4'b0000}, 1'b0);
  endtask

  task automatic test_backpressure();
    resp_t got, exp; int lat; logic [NB-1:0] cins; logic held, rdy;
    exp = ref_model(4'b1001, 1'b0, 1'b1, 16'h3C5A, 16'h4321);
    run_cmd(4'b1001, 1'b0, 1'b1, 16'h3C5A, 16'h4321, 5, got, lat, cins, held, rdy);
    vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL backpressure response: got %h expected %h", got, exp);
    end
    vectors++;
    if (held !== 1'b1) begin
      miscompares++; $display("FAIL backpressure hold: got %b expected 1", held);
    end
    vectors++;
    if (rdy !== 1'b1) begin
      miscompares++; $display("FAIL backpressure ready_after: got %b expected 1", rdy);
    end
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int n;
    n = 0;
    cmd_s = 4'b1001; cmd_m = 1'b0; cmd_cin = 1'b0; cmd_a = 16'h1111; cmd_b = 16'h2222;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
      if (cmd_ready) begin acc[n] = cyc; n++; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 20 && !cmd_ready; k++) begin @(posedge clk); #1; end
    rsp_ready = 1'b0;
    vectors++;
    if (n != 3) begin
      miscompares++; $display("FAIL back_to_back accepts: got %0d expected 3", n);
    end else begin
      for (int k = 1; k < 3; k++) begin
        vectors++;
        if (acc[k] - acc[k-1] != LAT + 2) begin
          miscompares++;
          $display("FAIL back_to_back spacing%0d: got %0d expected %0d", k, acc[k] - acc[k-1], LAT + 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    resp_t got, exp; int lat; logic [NB-1:0] cins; logic held, rdy;
    logic seen_valid;
    for (int k = 0; k < 20 && !cmd_ready; k++) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_s = 4'b1001; cmd_m = 1'b0; cmd_cin = 1'b1;
    cmd_a = 16'h8123; cmd_b = 16'h7456;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++; $display("FAIL mid_exec_reset_outputs: got %h expected 0", all_outs());
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_valid = 1'b1;
    end
    vectors++;
    if (seen_valid !== 1'b0) begin
      miscompares++; $display("FAIL mid_exec_no_response: got %b expected 0", seen_valid);
    end
    exp = ref_model(4'b0110, 1'b0, 1'b1, 16'h0100, 16'h0001);
    run_cmd(4'b0110, 1'b0, 1'b1, 16'h0100, 16'h0001, 0, got, lat, cins, held, rdy);
    vectors++;
    if (got !== exp || lat != LAT) begin
      miscompares++;
      $display("FAIL after_reset_cmd: got %h lat %0d expected %h lat %0d", got, lat, exp, LAT);
    end
  endtask

  task automatic test_random();
    resp_t got, exp; int lat; logic [NB-1:0] cins, exp_cins; logic held, rdy;
    logic [3:0] s; logic m, cin; logic [W-1:0] a, b;
    for (int n = 0; n < 150; n++) begin
      s = 4'($urandom); m = ($urandom_range(0, 3) == 0); cin = 1'($urandom);
      a = W'($urandom); b = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      exp = ref_model(s, m, cin, a, b);
      exp_cins = ref_cins(s, m, cin, a, b);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_cmd(s, m, cin, a, b, $urandom_range(0, 3), got, lat, cins, held, rdy);
      vectors++;
      if (got !== exp || lat != LAT) begin
        miscompares++;
        $display("FAIL random[%0d] s=%h m=%b cin=%b a=%h b=%h: got %h lat %0d expected %h lat %0d",
                 n, s, m, cin, a, b, got, lat, exp, LAT);
      end
      vectors++;
      if (cins !== exp_cins) begin
        miscompares++;
        $display("FAIL random[%0d] byte_cins s=%h m=%b: got %b expected %b", n, s, m, cins, exp_cins);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_ripple();
    test_subtract();
    test_overflow_zero();
    test_logic_xor();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
